bus_interconnect_rr: RTL and testbench

Parametrised multi-master, multi-slave system bus interconnect for a single-clock domain. It is the successor to the fixed 2-master/3-slave interconnect and adds:
- N-way round-robin arbitration.
- Parallel address and data buses of configurable width.
- Decode errors on out-of-range slave selects.
- A transfer timeout watchdog.

It sits between all bus masters and slave peripherals and owns both arbitration and routing.

---
 rtl/bus_interconnect_rr_if.sv | 43 ++++
 rtl/bus_interconnect_rr.sv | 169 ++++++++++++++++
 tb/tb_bus_interconnect_rr.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_interconnect_rr_if.sv
// Bus bundle for the round-robin interconnect: master modport is the interconnect's view,
// slave modport is the view of the attached masters/slaves driving the other side.
interface bus_interconnect_rr_if #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned N_SLAVES  = 3,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8
);
  logic [N_MASTERS-1:0]        m_request;
  logic [N_MASTERS*SEL_W-1:0]  m_slave_sel;
  logic [N_MASTERS-1:0]        m_grant;
  logic                        arbiter_busy;
  logic [N_MASTERS-1:0]        m_valid;
  logic [N_MASTERS-1:0]        m_write_en;
  logic [N_MASTERS-1:0]        m_read_en;
  logic [N_MASTERS*ADDR_W-1:0] m_tx_address;
  logic [N_MASTERS*DATA_W-1:0] m_tx_data;
  logic [N_MASTERS*DATA_W-1:0] m_rx_data;
  logic [N_MASTERS-1:0]        m_slave_ready;
  logic [N_MASTERS-1:0]        m_error;
  logic [N_SLAVES-1:0]         s_valid;
  logic [N_SLAVES-1:0]         s_write_en;
  logic [N_SLAVES-1:0]         s_read_en;
  logic [N_SLAVES*ADDR_W-1:0]  s_rx_address;
  logic [N_SLAVES*DATA_W-1:0]  s_rx_data;
  logic [N_SLAVES*DATA_W-1:0]  s_tx_data;
  logic [N_SLAVES-1:0]         s_slave_ready;

  modport master (
    input  m_request, m_slave_sel, m_valid, m_write_en, m_read_en,
    input  m_tx_address, m_tx_data, s_tx_data, s_slave_ready,
    output m_grant, arbiter_busy, m_rx_data, m_slave_ready, m_error,
    output s_valid, s_write_en, s_read_en, s_rx_address, s_rx_data
  );

  modport slave (
    output m_request, m_slave_sel, m_valid, m_write_en, m_read_en,
    output m_tx_address, m_tx_data, s_tx_data, s_slave_ready,
    input  m_grant, arbiter_busy, m_rx_data, m_slave_ready, m_error,
    input  s_valid, s_write_en, s_read_en, s_rx_address, s_rx_data
  );
endinterface

// File: rtl/bus_interconnect_rr.sv
// N-master / M-slave bus interconnect with round-robin arbitration, decode-error
// reporting and a per-tenure timeout watchdog.
module bus_interconnect_rr #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned N_SLAVES  = 3,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  bus_interconnect_rr_if.master bus
);
  localparam int unsigned OWN_W = $clog2(N_MASTERS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_e;

  state_e               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     last_q, last_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 win_found;
  logic [OWN_W-1:0]     win_idx;
  logic [SEL_W-1:0]     win_sel;
  logic [N_MASTERS-1:0] win_grant;
  logic                 own_req, own_valid, sel_ready;

  // Rotating priority: slot k of the search visits master (last+k) mod N_MASTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_sel   = '0;
    win_grant = '0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      for (int unsigned j = 0; j < N_MASTERS; j++) begin
        if (!win_found && bus.m_request[j] && (((32'(last_q) + k) % N_MASTERS) == j)) begin
          win_found    = 1'b1;
          win_idx      = OWN_W'(j);
          win_sel      = bus.m_slave_sel[j*SEL_W +: SEL_W];
          win_grant[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    own_req   = 1'b0;
    own_valid = 1'b0;
    sel_ready = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (owner_q == OWN_W'(i)) begin
        own_req   = bus.m_request[i];
        own_valid = bus.m_valid[i];
      end
    end
    for (int unsigned j = 0; j < N_SLAVES; j++) begin
      if (sel_q == SEL_W'(j)) sel_ready = bus.s_slave_ready[j];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          owner_d = win_idx;
          sel_d   = win_sel;
          // An out-of-range select never reaches the bus, so no grant is shown for it.
          if (32'(win_sel) < N_SLAVES) begin
            state_d = ST_BUSY;
            grant_d = win_grant;
          end else begin
            state_d = ST_ERR;
            grant_d = '0;
          end
        end
      end
      ST_BUSY: begin
        if (!own_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (own_valid && !sel_ready) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = ST_ERR;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        grant_d = '0;
        last_d  = owner_q;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      last_q  <= OWN_W'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.m_grant      = grant_q;
  assign bus.arbiter_busy = (state_q != ST_IDLE);

  always_comb begin
    bus.m_rx_data     = '0;
    bus.m_slave_ready = '0;
    bus.m_error       = '0;
    bus.s_valid       = '0;
    bus.s_write_en    = '0;
    bus.s_read_en     = '0;
    bus.s_rx_address  = '0;
    bus.s_rx_data     = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      for (int unsigned j = 0; j < N_SLAVES; j++) begin
        if (state_q == ST_BUSY && owner_q == OWN_W'(i) && sel_q == SEL_W'(j)) begin
          bus.s_valid[j]                          = bus.m_valid[i];
          bus.s_write_en[j]                       = bus.m_write_en[i];
          bus.s_read_en[j]                        = bus.m_read_en[i];
          bus.s_rx_address[j*ADDR_W +: ADDR_W]    = bus.m_tx_address[i*ADDR_W +: ADDR_W];
          bus.s_rx_data[j*DATA_W +: DATA_W]       = bus.m_tx_data[i*DATA_W +: DATA_W];
          bus.m_slave_ready[i]                    = bus.s_slave_ready[j];
          bus.m_rx_data[i*DATA_W +: DATA_W]       = bus.s_tx_data[j*DATA_W +: DATA_W];
        end
      end
      if (state_q == ST_ERR && owner_q == OWN_W'(i)) begin
        bus.m_error[i]       = 1'b1;
        bus.m_slave_ready[i] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bus_interconnect_rr.sv
// Scoreboard bench for bus_interconnect_rr: grant, error and transfer-completion events
// are queued when driven and checked by a monitor as the DUT produces them.
module tb_bus_interconnect_rr;
  localparam int unsigned NM = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 3;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  typedef struct { logic [3:0] g; int c; } gr_t;
  typedef struct { int m; int c; } er_t;
  typedef struct {
    int m; int s; logic [11:0] a; logic [7:0] d; logic we; logic re; logic [7:0] rd;
  } xf_t;

  logic clk = 1'b0;
  logic sys_rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ngr[4];
  gr_t  eg_q[$];
  er_t  ee_q[$];
  xf_t  ex_q[$];
  gr_t  ge;
  er_t  ee;
  xf_t  xe;
  logic [3:0] prev_g = '0;

  bus_interconnect_rr_if #(
    .N_MASTERS(NM), .N_SLAVES(NS), .SEL_W(SW), .ADDR_W(AW), .DATA_W(DW)
  ) bus ();

  bus_interconnect_rr #(
    .N_MASTERS(NM), .N_SLAVES(NS), .SEL_W(SW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic [2:0] sel, input logic v,
                       input logic we, input logic re, input logic [11:0] a, input logic [7:0] d);
    bus.m_request[m]           = req;
    bus.m_slave_sel[m*SW +: SW] = sel;
    bus.m_valid[m]             = v;
    bus.m_write_en[m]          = we;
    bus.m_read_en[m]           = re;
    bus.m_tx_address[m*AW +: AW] = a;
    bus.m_tx_data[m*DW +: DW]  = d;
  endtask

  task automatic idle_all();
    bus.m_request     = '0;
    bus.m_slave_sel   = '0;
    bus.m_valid       = '0;
    bus.m_write_en    = '0;
    bus.m_read_en     = '0;
    bus.m_tx_address  = '0;
    bus.m_tx_data     = '0;
    bus.s_slave_ready = '0;
    bus.s_tx_data     = 24'hA2A1A0;
  endtask

  task automatic decode_case(input int m, input logic [2:0] sel);
    int c0;
    tick();
    c0 = cyc;
    set_m(m, 1'b1, sel, 1'b1, 1'b1, 1'b0, 12'h055, 8'h99);
    ee_q.push_back('{m: m, c: c0 + 1});
    tick();
    set_m(m, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    #2 chk("dec_busy_in_err", 64'(bus.arbiter_busy), 64'd1);
    tick();
    #2 chk("dec_idle_after", 64'(bus.arbiter_busy), 64'd0);
  endtask

  // Monitor: grant rises, error pulses and completed transfers are matched against the queues.
  always @(negedge clk) begin
    if (bus.m_grant != '0 && prev_g == '0) begin
      if (eg_q.size() == 0) chk("grant_unexpected", 64'(bus.m_grant), 64'd0);
      else begin
        ge = eg_q.pop_front();
        chk("grant_vec", 64'(bus.m_grant), 64'(ge.g));
        chk("grant_cycle", 64'(cyc), 64'(ge.c));
      end
    end
    prev_g = bus.m_grant;
    if (bus.m_error != '0) begin
      if (ee_q.size() == 0) chk("error_unexpected", 64'(bus.m_error), 64'd0);
      else begin
        ee = ee_q.pop_front();
        chk("err_vec", 64'(bus.m_error), 64'd1 << ee.m);
        chk("err_ready", 64'(bus.m_slave_ready), 64'd1 << ee.m);
        chk("err_s_valid", 64'(bus.s_valid), 64'd0);
        chk("err_grant", 64'(bus.m_grant), 64'd0);
        chk("err_cycle", 64'(cyc), 64'(ee.c));
      end
    end else if (bus.m_slave_ready != '0) begin
      if (ex_q.size() == 0) chk("xfer_unexpected", 64'(bus.m_slave_ready), 64'd0);
      else begin
        xe = ex_q.pop_front();
        chk("xf_m_ready", 64'(bus.m_slave_ready), 64'd1 << xe.m);
        chk("xf_s_valid", 64'(bus.s_valid), 64'd1 << xe.s);
        chk("xf_s_we", 64'(bus.s_write_en), 64'(xe.we) << xe.s);
        chk("xf_s_re", 64'(bus.s_read_en), 64'(xe.re) << xe.s);
        chk("xf_s_addr", 64'(bus.s_rx_address), 64'(xe.a) << (xe.s * AW));
        chk("xf_s_data", 64'(bus.s_rx_data), 64'(xe.d) << (xe.s * DW));
        chk("xf_m_rx", 64'(bus.m_rx_data), 64'(xe.rd) << (xe.m * DW));
      end
    end
  end

  initial begin
    int c0;
    int m;
    idle_all();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    #2;
    chk("rst_grant", 64'(bus.m_grant), 64'd0);
    chk("rst_busy", 64'(bus.arbiter_busy), 64'd0);
    chk("rst_m_out", 64'({bus.m_error, bus.m_slave_ready, bus.m_rx_data}), 64'd0);
    chk("rst_s_strb", 64'({bus.s_valid, bus.s_write_en, bus.s_read_en}), 64'd0);

    // Round robin: every master requests; each releases in its grant cycle, M0 re-requests.
    tick();
    c0 = cyc;
    bus.s_slave_ready = '1;
    for (int i = 0; i < 4; i++) begin
      set_m(i, 1'b1, 3'(i % 3), 1'b1, (i % 2 == 0), (i % 2 == 1), 12'(12'h100 + i), 8'(8'h10 + i));
      ngr[i] = 0;
    end
    for (int k = 0; k < 5; k++) begin
      m = k % 4;
      eg_q.push_back('{g: 4'(1 << m), c: c0 + 1 + 2 * k});
      ex_q.push_back('{m: m, s: m % 3, a: 12'(12'h100 + m), d: 8'(8'h10 + m),
                       we: (m % 2 == 0), re: (m % 2 == 1), rd: 8'(8'hA0 + m % 3)});
    end
    for (int n = 0; n < 12; n++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (bus.m_grant[i]) begin
          bus.m_request[i] = 1'b0;
          ngr[i]++;
        end else if (i == 0 && ngr[0] == 1) begin
          bus.m_request[0] = 1'b1;
        end
      end
    end
    chk("rr_grants_m0", 64'(ngr[0]), 64'd2);
    chk("rr_grants_m3", 64'(ngr[3]), 64'd1);
    idle_all();

    // Single master write: M2 -> slave 1.
    tick();
    c0 = cyc;
    set_m(2, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 12'h0A5, 8'h3C);
    eg_q.push_back('{g: 4'b0100, c: c0 + 1});
    ex_q.push_back('{m: 2, s: 1, a: 12'h0A5, d: 8'h3C, we: 1'b1, re: 1'b0, rd: 8'hA1});
    tick();
    bus.s_slave_ready[1] = 1'b1;
    tick();
    bus.s_slave_ready = '0;
    set_m(2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    #2 chk("wr_busy_release_cycle", 64'(bus.arbiter_busy), 64'd1);
    tick();
    #2;
    chk("wr_grant_dropped", 64'(bus.m_grant), 64'd0);
    chk("wr_busy_dropped", 64'(bus.arbiter_busy), 64'd0);

    // Decode errors: far out of range, and the first index past the last slave.
    decode_case(1, 3'd5);
    decode_case(2, 3'd3);

    // Read path: M3 reads slave 2 (highest valid index).
    tick();
    c0 = cyc;
    set_m(3, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 12'h3F0, 8'h00);
    eg_q.push_back('{g: 4'b1000, c: c0 + 1});
    ex_q.push_back('{m: 3, s: 2, a: 12'h3F0, d: 8'h00, we: 1'b0, re: 1'b1, rd: 8'hA7});
    tick();
    bus.s_tx_data        = 24'hA72211;
    bus.s_slave_ready[2] = 1'b1;
    bus.m_request[3]     = 1'b0;
    tick();
    idle_all();

    // Timeout: M0 waits on slave 0 forever; M3 arrives meanwhile and wins the next round.
    tick();
    c0 = cyc;
    set_m(0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 12'h777, 8'h5A);
    eg_q.push_back('{g: 4'b0001, c: c0 + 1});
    ee_q.push_back('{m: 0, c: c0 + 1 + TO});
    eg_q.push_back('{g: 4'b1000, c: c0 + 3 + TO});
    eg_q.push_back('{g: 4'b0001, c: c0 + 5 + TO});
    repeat (3) tick();
    set_m(3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    repeat (2) tick();
    #2;
    chk("to_busy_waiting", 64'(bus.arbiter_busy), 64'd1);
    chk("to_no_early_error", 64'(bus.m_error), 64'd0);
    while (cyc < c0 + 3 + int'(TO)) tick();
    bus.m_request[3] = 1'b0;
    while (cyc < c0 + 5 + int'(TO)) tick();
    set_m(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    tick();
    idle_all();

    // Short M1 tenure so the rotation pointer sits at 1 before the reset test.
    tick();
    c0 = cyc;
    set_m(1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    eg_q.push_back('{g: 4'b0010, c: c0 + 1});
    tick();
    bus.m_request[1] = 1'b0;
    tick();

    // Reset in the middle of an M3 tenure with M1 and M2 waiting.
    tick();
    c0 = cyc;
    set_m(3, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 12'h222, 8'h33);
    eg_q.push_back('{g: 4'b1000, c: c0 + 1});
    tick();
    bus.m_request[1] = 1'b1;
    bus.m_request[2] = 1'b1;
    tick();
    sys_rst = 1'b1;
    #2 chk("pre_rst_s_valid", 64'(bus.s_valid), 64'b100);
    tick();
    sys_rst = 1'b0;
    bus.m_request[3] = 1'b0;
    #2;
    chk("mid_rst_grant", 64'(bus.m_grant), 64'd0);
    chk("mid_rst_busy", 64'(bus.arbiter_busy), 64'd0);
    chk("mid_rst_s_strb", 64'({bus.s_valid, bus.s_write_en, bus.s_read_en}), 64'd0);
    chk("mid_rst_s_addr", 64'(bus.s_rx_address), 64'd0);
    chk("mid_rst_s_data", 64'(bus.s_rx_data), 64'd0);
    chk("mid_rst_m_out", 64'({bus.m_error, bus.m_slave_ready, bus.m_rx_data}), 64'd0);
    eg_q.push_back('{g: 4'b0010, c: cyc + 1});
    tick();
    bus.m_request[1] = 1'b0;
    tick();
    idle_all();
    repeat (3) tick();

    chk("left_grant_events", 64'(eg_q.size()), 64'd0);
    chk("left_error_events", 64'(ee_q.size()), 64'd0);
    chk("left_xfer_events", 64'(ex_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
